// File: rtl/snes_pkg.sv
// Shared SNES pad definitions: button bit positions, FSM encoding and frame length.
// Also used by the host-side controller reader.
package snes_pkg;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int NUM_BUTTONS    = 12;
    localparam int FRAME_BITS_DEF = 16;

    typedef logic [1:0] pad_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/snes_pad_emulator_if.sv
// Pad-side bus: host shift clock/latch and button inputs, serial line and status outputs.
interface snes_pad_emulator_if;
    import snes_pkg::*;

    logic                   snes_clk;
    logic                   data_latch;
    logic [NUM_BUTTONS-1:0] button_data;
    logic                   serial_data;
    logic                   busy;
    logic                   frame_done;
    logic                   proto_err;

    modport master (
        output snes_clk, data_latch, button_data,
        input  serial_data, busy, frame_done, proto_err
    );

    modport slave (
        input  snes_clk, data_latch, button_data,
        output serial_data, busy, frame_done, proto_err
    );

endinterface

// File: rtl/snes_pad_emulator_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by an edge-detect flop
// producing single-cycle rise/fall pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/snes_pad_emulator.sv
// SNES controller emulator: latches the button word on the host latch pulse and
// shifts it out LSB-first, active-low, on host shift-clock rising edges.
module snes_pad_emulator import snes_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    snes_pad_emulator_if.slave        pad
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  w_clk_rise;
    logic                  w_clk_fall;
    logic                  w_lat_rise;
    logic                  w_lat_fall;
    logic [FRAME_BITS-1:0] w_load;
    pad_state_t            w_state_nxt;

    pad_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_cnt;
    logic                  r_serial;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_perr;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk     (clk),
        .rst     (reset),
        .i_async (pad.snes_clk),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lat (
        .clk     (clk),
        .rst     (reset),
        .i_async (pad.data_latch),
        .o_rise  (w_lat_rise),
        .o_fall  (w_lat_fall)
    );

    // Unused upper frame bits read as released buttons.
    assign w_load = {{(FRAME_BITS-NUM_BUTTONS){1'b1}}, ~pad.button_data};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_lat_rise) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_lat_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                // A latch edge aborts the frame, even if a shift edge lands in the same cycle.
                if (w_lat_rise)
                    w_state_nxt = ST_LOAD;
                else if (w_clk_rise && r_cnt == LAST_BIT)
                    w_state_nxt = ST_DONE;
            end
            default:  w_state_nxt = w_lat_rise ? ST_LOAD : ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '1;
            r_cnt    <= '0;
            r_serial <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_LOAD: begin
                    r_shift <= w_load;
                    r_cnt   <= '0;
                end
                ST_SHIFT: begin
                    if (!w_lat_rise && w_clk_rise && r_cnt != LAST_BIT) begin
                        r_shift <= {1'b0, r_shift[FRAME_BITS-1:1]};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
            r_serial <= (r_state == ST_LOAD || r_state == ST_SHIFT) ? r_shift[0] : 1'b0;
            r_busy   <= (w_state_nxt == ST_LOAD || w_state_nxt == ST_SHIFT);
            r_done   <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
            // Host must not clock while the latch is high; remember it until reset.
            r_perr   <= r_perr | ((r_state == ST_LOAD) && w_clk_fall);
        end
    end

    assign pad.serial_data = r_serial;
    assign pad.busy        = r_busy;
    assign pad.frame_done  = r_done;
    assign pad.proto_err   = r_perr;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Directed and randomized host transactions against the SNES pad emulator, checked
// against a per-bit model of the expected serial stream.
module tb_snes_pad_emulator;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   n_done;

    snes_pad_emulator_if u_if ();

    snes_pad_emulator #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (u_if)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial n_done = 0;
    always @(posedge clk) begin
        if (u_if.frame_done === 1'b1) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pressed button reads 0 on the line; bits beyond the 12 buttons read 1.
    function automatic logic [31:0] model_stream(input logic [11:0] btn);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) s[k] = (k < 12) ? !btn[k] : 1'b1;
        return s;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch_pulse(input int len, input int gap);
        u_if.data_latch = 1'b1;
        wait_clks(len);
        u_if.data_latch = 1'b0;
        wait_clks(gap);
    endtask

    task automatic pulses(input int n, input int half, input int chg_at,
                          input logic [11:0] chg_val, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) u_if.button_data = chg_val;
            u_if.snes_clk = 1'b0;
            cap[i] = u_if.serial_data;
            wait_clks(half);
            u_if.snes_clk = 1'b1;
            wait_clks(half);
        end
    endtask

    task automatic run_frame(input logic [11:0] btn, input int latch_len, input int half,
                             output logic [31:0] cap);
        u_if.button_data = btn;
        latch_pulse(latch_len, half);
        pulses(16, half, -1, 12'h000, cap);
        wait_clks(10);
    endtask

    initial begin
        logic [31:0] cap;
        logic [11:0] btn;
        int          d0;
        int          half;
        int          llen;
        logic        flag_a;
        logic        flag_b;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        u_if.snes_clk    = 1'b1;
        u_if.data_latch  = 1'b0;
        u_if.button_data = 12'h000;

        wait_clks(3);
        check("rst_serial", {31'd0, u_if.serial_data}, 32'd0);
        check("rst_busy",   {31'd0, u_if.busy},        32'd0);
        check("rst_done",   {31'd0, u_if.frame_done},  32'd0);
        check("rst_perr",   {31'd0, u_if.proto_err},   32'd0);
        reset = 1'b0;
        wait_clks(10);

        // Single B press, mid-frame busy sample.
        d0 = n_done;
        u_if.button_data = 12'h001;
        latch_pulse(300, 150);
        check("b_busy_mid", {31'd0, u_if.busy}, 32'd1);
        pulses(16, 150, -1, 12'h000, cap);
        wait_clks(10);
        check("b_stream",     cap, model_stream(12'h001));
        check("b_serial_end", {31'd0, u_if.serial_data}, 32'd0);
        check("b_busy_end",   {31'd0, u_if.busy}, 32'd0);
        check("b_done_cnt",   n_done - d0, 32'd1);
        check("b_perr",       {31'd0, u_if.proto_err}, 32'd0);

        d0 = n_done;
        run_frame(12'hA50, 300, 150, cap);
        check("a50_stream", cap, 32'h0000_F5AF);
        check("a50_done",   n_done - d0, 32'd1);

        // Buttons change mid-frame: current frame keeps the latched word.
        d0 = n_done;
        u_if.button_data = 12'h000;
        latch_pulse(300, 150);
        pulses(16, 150, 4, 12'hFFF, cap);
        wait_clks(10);
        check("chg_stream", cap, model_stream(12'h000));
        run_frame(12'hFFF, 300, 150, cap);
        check("chg_next",   cap, model_stream(12'hFFF));
        check("chg_done",   n_done - d0, 32'd2);

        // Abort after 7 bits with a new latch.
        d0 = n_done;
        u_if.button_data = 12'h0F0;
        latch_pulse(300, 150);
        pulses(7, 150, -1, 12'h000, cap);
        u_if.button_data = 12'h30C;
        flag_a = 1'b0;
        u_if.data_latch = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (u_if.busy !== 1'b1) flag_a = 1'b1;
        end
        u_if.data_latch = 1'b0;
        wait_clks(150);
        check("abort_busy", {31'd0, flag_a}, 32'd0);
        pulses(16, 150, -1, 12'h000, cap);
        wait_clks(10);
        check("abort_stream", cap, model_stream(12'h30C));
        check("abort_done",   n_done - d0, 32'd1);

        // Reset mid-shift, then clocking without a latch.
        d0 = n_done;
        u_if.button_data = 12'h0AA;
        latch_pulse(300, 40);
        pulses(5, 40, -1, 12'h000, cap);
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(10);
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            u_if.snes_clk = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (u_if.serial_data !== 1'b0) flag_a = 1'b1;
                if (u_if.busy !== 1'b0) flag_b = 1'b1;
            end
            u_if.snes_clk = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (u_if.serial_data !== 1'b0) flag_a = 1'b1;
                if (u_if.busy !== 1'b0) flag_b = 1'b1;
            end
        end
        check("rstmid_serial", {31'd0, flag_a}, 32'd0);
        check("rstmid_busy",   {31'd0, flag_b}, 32'd0);
        check("rstmid_done",   n_done - d0, 32'd0);

        // Shift clock pulsed while latch is high.
        d0 = n_done;
        u_if.button_data = 12'h5A3;
        u_if.data_latch = 1'b1;
        wait_clks(100);
        u_if.snes_clk = 1'b0;
        wait_clks(20);
        u_if.snes_clk = 1'b1;
        wait_clks(180);
        u_if.data_latch = 1'b0;
        wait_clks(40);
        check("perr_set", {31'd0, u_if.proto_err}, 32'd1);
        pulses(16, 40, -1, 12'h000, cap);
        wait_clks(10);
        check("perr_stream", cap, model_stream(12'h5A3));
        check("perr_done",   n_done - d0, 32'd1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            btn  = 12'($urandom);
            half = $urandom_range(8, 40);
            llen = $urandom_range(300, 360);
            d0   = n_done;
            run_frame(btn, llen, half, cap);
            check("rnd_stream", cap, model_stream(btn));
            check("rnd_done",   n_done - d0, 32'd1);
        end
        check("perr_sticky", {31'd0, u_if.proto_err}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
